// File: rtl/axis_srl_fifo_depth.sv
// Parametrised-depth AXI4-Stream FIFO built on a shift register with a count-indexed read tap.
// Storage has no reset so it maps onto SRL primitives; only the count and status flags reset.
module axis_srl_fifo_depth #(
    parameter int DEPTH             = 16,
    parameter int DATA_WIDTH        = 8,
    parameter int KEEP_ENABLE       = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH        = ((DATA_WIDTH + 7) / 8),
    parameter int LAST_ENABLE       = 1,
    parameter int ID_ENABLE         = 0,
    parameter int ID_WIDTH          = 8,
    parameter int DEST_ENABLE       = 0,
    parameter int DEST_WIDTH        = 8,
    parameter int USER_ENABLE       = 1,
    parameter int USER_WIDTH        = 1,
    parameter int ALMOST_FULL_LEVEL = DEPTH - 2,
    localparam int CW               = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,

    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [ID_WIDTH-1:0]   s_axis_tid,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [USER_WIDTH-1:0] m_axis_tuser,

    output logic [CW-1:0]         status_count,
    output logic                  status_full,
    output logic                  status_empty,
    output logic                  status_almost_full
);

    localparam int AW       = $clog2(DEPTH);
    localparam int KEEP_OFF = DATA_WIDTH;
    localparam int LAST_OFF = KEEP_OFF + ((KEEP_ENABLE != 0) ? KEEP_WIDTH : 0);
    localparam int ID_OFF   = LAST_OFF + ((LAST_ENABLE != 0) ? 1 : 0);
    localparam int DEST_OFF = ID_OFF + ((ID_ENABLE != 0) ? ID_WIDTH : 0);
    localparam int USER_OFF = DEST_OFF + ((DEST_ENABLE != 0) ? DEST_WIDTH : 0);
    localparam int WW       = USER_OFF + ((USER_ENABLE != 0) ? USER_WIDTH : 0);

    logic [WW-1:0]   r_sr [DEPTH];
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_almost_full;

    logic [WW-1:0]   w_s_word;
    logic [WW-1:0]   w_m_word;
    logic [AW-1:0]   w_tap_idx;
    logic [CW-1:0]   w_count_next;
    logic            w_wr_en;
    logic            w_rd_en;
    logic            w_unused_sideband;

    // Disabled sideband inputs are intentionally dropped.
    assign w_unused_sideband = ^{s_axis_tkeep, s_axis_tlast, s_axis_tid, s_axis_tdest,
                                 s_axis_tuser};

    assign w_s_word[DATA_WIDTH-1:0] = s_axis_tdata;
    assign m_axis_tdata             = w_m_word[DATA_WIDTH-1:0];

    if (KEEP_ENABLE != 0) begin : g_keep
        assign w_s_word[KEEP_OFF +: KEEP_WIDTH] = s_axis_tkeep;
        assign m_axis_tkeep = w_m_word[KEEP_OFF +: KEEP_WIDTH];
    end else begin : g_no_keep
        assign m_axis_tkeep = '1;
    end

    if (LAST_ENABLE != 0) begin : g_last
        assign w_s_word[LAST_OFF] = s_axis_tlast;
        assign m_axis_tlast = w_m_word[LAST_OFF];
    end else begin : g_no_last
        assign m_axis_tlast = 1'b1;
    end

    if (ID_ENABLE != 0) begin : g_id
        assign w_s_word[ID_OFF +: ID_WIDTH] = s_axis_tid;
        assign m_axis_tid = w_m_word[ID_OFF +: ID_WIDTH];
    end else begin : g_no_id
        assign m_axis_tid = '0;
    end

    if (DEST_ENABLE != 0) begin : g_dest
        assign w_s_word[DEST_OFF +: DEST_WIDTH] = s_axis_tdest;
        assign m_axis_tdest = w_m_word[DEST_OFF +: DEST_WIDTH];
    end else begin : g_no_dest
        assign m_axis_tdest = '0;
    end

    if (USER_ENABLE != 0) begin : g_user
        assign w_s_word[USER_OFF +: USER_WIDTH] = s_axis_tuser;
        assign m_axis_tuser = w_m_word[USER_OFF +: USER_WIDTH];
    end else begin : g_no_user
        assign m_axis_tuser = '0;
    end

    // Full blocks writes even when a read happens in the same cycle.
    assign w_wr_en = s_axis_tvalid && !r_full && !flush && !rst;
    assign w_rd_en = (r_count != '0) && m_axis_tready && !flush;

    // Oldest entry sits at count-1; the tap index wraps harmlessly when empty.
    assign w_tap_idx = AW'(r_count - CW'(1));
    assign w_m_word  = r_sr[w_tap_idx];

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = '0;
        end else if (w_wr_en && !w_rd_en) begin
            w_count_next = r_count + CW'(1);
        end else if (!w_wr_en && w_rd_en) begin
            w_count_next = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_sr[0] <= w_s_word;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_full        <= 1'b0;
            r_empty       <= 1'b1;
            r_almost_full <= 1'b0;
        end else begin
            r_count       <= w_count_next;
            r_full        <= (w_count_next == CW'(DEPTH));
            r_empty       <= (w_count_next == '0);
            r_almost_full <= (w_count_next >= CW'(ALMOST_FULL_LEVEL));
        end
    end

    assign s_axis_tready      = !r_full;
    assign m_axis_tvalid      = (r_count != '0);
    assign status_count       = r_count;
    assign status_full        = r_full;
    assign status_empty       = r_empty;
    assign status_almost_full = r_almost_full;

endmodule

// File: tb/tb_axis_srl_fifo_depth.sv
// Directed and scoreboarded bench for axis_srl_fifo_depth at DEPTH=4, 8-bit data.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_axis_srl_fifo_depth;

    localparam int DEPTH = 4;
    localparam int DW    = 8;
    localparam int KW    = 1;
    localparam int IW    = 8;
    localparam int DSW   = 8;
    localparam int UW    = 1;
    localparam int CW    = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic [DW-1:0]  s_tdata;
    logic [KW-1:0]  s_tkeep;
    logic           s_tvalid;
    logic           s_tready;
    logic           s_tlast;
    logic [IW-1:0]  s_tid;
    logic [DSW-1:0] s_tdest;
    logic [UW-1:0]  s_tuser;
    logic [DW-1:0]  m_tdata;
    logic [KW-1:0]  m_tkeep;
    logic           m_tvalid;
    logic           m_tready;
    logic           m_tlast;
    logic [IW-1:0]  m_tid;
    logic [DSW-1:0] m_tdest;
    logic [UW-1:0]  m_tuser;
    logic [CW-1:0]  st_count;
    logic           st_full;
    logic           st_empty;
    logic           st_af;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    axis_srl_fifo_depth #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW)
    ) u_dut (
        .clk                (clk),
        .rst                (rst),
        .flush              (flush),
        .s_axis_tdata       (s_tdata),
        .s_axis_tkeep       (s_tkeep),
        .s_axis_tvalid      (s_tvalid),
        .s_axis_tready      (s_tready),
        .s_axis_tlast       (s_tlast),
        .s_axis_tid         (s_tid),
        .s_axis_tdest       (s_tdest),
        .s_axis_tuser       (s_tuser),
        .m_axis_tdata       (m_tdata),
        .m_axis_tkeep       (m_tkeep),
        .m_axis_tvalid      (m_tvalid),
        .m_axis_tready      (m_tready),
        .m_axis_tlast       (m_tlast),
        .m_axis_tid         (m_tid),
        .m_axis_tdest       (m_tdest),
        .m_axis_tuser       (m_tuser),
        .status_count       (st_count),
        .status_full        (st_full),
        .status_empty       (st_empty),
        .status_almost_full (st_af)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] got_q[$];
        logic [9:0] sb[$];
        logic [9:0] exp_w;
        int  acc_iter;
        int  err;
        int  sb_err;
        int  cnt_err;
        int  n_sent;
        int  n_recv;
        bit  in_hs;
        bit  out_hs;

        rst = 1'b1; flush = 1'b0;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        s_tid = '0; s_tdest = '0; s_tuser = '0; m_tready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_count",  32'(st_count), 0);
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_tready", 32'(s_tready), 1);
        check("rst_empty",  32'(st_empty), 1);
        check("rst_full",   32'(st_full),  0);
        check("rst_af",     32'(st_af),    0);

        // 1: fill with no reader
        for (int i = 0; i < 4; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'((i + 1) * 8'h11);
            tick();
            check("fill_count",  32'(st_count), 32'(i + 1));
            check("fill_head",   32'(m_tdata),  32'h11);
            check("fill_af",     32'(st_af),    32'((i + 1) >= 2));
            check("fill_full",   32'(st_full),  32'(i == 3));
            check("fill_tready", 32'(s_tready), 32'(i != 3));
        end
        s_tvalid = 1'b0;
        check("fill_keep", 32'(m_tkeep), 32'h1);
        check("fill_id",   32'(m_tid),   32'h0);

        // 2: drain from full while offering 0x55
        m_tready = 1'b1; s_tvalid = 1'b1; s_tdata = 8'h55;
        acc_iter = -1;
        for (int it = 0; it < 12 && got_q.size() < 5; it++) begin
            if (m_tvalid) got_q.push_back(m_tdata);
            if (s_tvalid && s_tready) acc_iter = it;
            tick();
            if (acc_iter == it) s_tvalid = 1'b0;
        end
        s_tvalid = 1'b0;
        check("drain_n",   32'(got_q.size()), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            check("drain_word", 32'(got_q[i]), 32'((i + 1) * 8'h11));
        end
        check("drain_acc_cycle", 32'(acc_iter), 1);
        check("drain_count",     32'(st_count), 0);
        check("drain_empty",     32'(st_empty), 1);

        // 3: continuous streaming
        err = 0;
        for (int i = 0; i < 100; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(i);
            tick();
            if (st_count != 3'd1 || m_tdata != 8'(i) || !m_tvalid) err++;
        end
        s_tvalid = 1'b0;
        check("stream_errs", 32'(err), 0);
        tick();
        check("stream_final_count", 32'(st_count), 0);

        // 4: random handshakes against a scoreboard
        n_sent = 0; n_recv = 0; sb_err = 0; cnt_err = 0;
        for (int cyc = 0; cyc < 20000 && n_recv < 1000; cyc++) begin
            s_tvalid = (n_sent < 1000) && ($urandom_range(0, 1) == 1);
            m_tready = ($urandom_range(0, 1) == 1);
            s_tdata  = 8'(n_sent * 37 + 5);
            s_tlast  = ((n_sent % 7) == 6);
            s_tuser  = s_tdata[0];
            in_hs    = s_tvalid && s_tready;
            out_hs   = m_tvalid && m_tready;
            if (out_hs) begin
                if (sb.size() == 0) begin
                    sb_err++;
                end else begin
                    exp_w = sb.pop_front();
                    if ({m_tlast, m_tuser, m_tdata} !== exp_w) sb_err++;
                end
                n_recv++;
            end
            if (in_hs) begin
                sb.push_back({s_tlast, s_tuser, s_tdata});
                n_sent++;
            end
            tick();
            if (st_count > 3'd4 || 32'(st_count) != sb.size()) cnt_err++;
        end
        s_tvalid = 1'b0; m_tready = 1'b0; s_tlast = 1'b0; s_tuser = '0;
        check("rand_recv",    32'(n_recv),  1000);
        check("rand_sb_errs", 32'(sb_err),  0);
        check("rand_cnt_errs",32'(cnt_err), 0);

        // 5: flush with concurrent write and read
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 8'(8'hA0 + i);
            tick();
        end
        check("preflush_count", 32'(st_count), 3);
        flush = 1'b1; s_tvalid = 1'b1; s_tdata = 8'hEE; m_tready = 1'b1;
        tick();
        flush = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
        check("flush_count",  32'(st_count), 0);
        check("flush_empty",  32'(st_empty), 1);
        check("flush_tvalid", 32'(m_tvalid), 0);
        check("flush_af",     32'(st_af),    0);
        s_tvalid = 1'b1; s_tdata = 8'h5A;
        tick();
        s_tvalid = 1'b0;
        check("postflush_count", 32'(st_count), 1);
        check("postflush_data",  32'(m_tdata),  32'h5A);

        // 6: reset with a write pending
        s_tvalid = 1'b1; s_tdata = 8'h66;
        tick();
        check("prerst_count", 32'(st_count), 2);
        rst = 1'b1; s_tdata = 8'h77;
        tick();
        rst = 1'b0; s_tvalid = 1'b0;
        check("midrst_count",  32'(st_count), 0);
        check("midrst_tvalid", 32'(m_tvalid), 0);
        check("midrst_tready", 32'(s_tready), 1);
        check("midrst_empty",  32'(st_empty), 1);
        check("midrst_af",     32'(st_af),    0);
        s_tvalid = 1'b1; s_tdata = 8'hAB;
        tick();
        s_tvalid = 1'b0;
        check("postrst_count",  32'(st_count), 1);
        check("postrst_data",   32'(m_tdata),  32'hAB);
        check("postrst_tvalid", 32'(m_tvalid), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
